// File: rtl/bcdcnt_pkg.sv
// Shared constants and helpers for the BCD modulo counter.
// - BCD_W          : bits per decade
// - BCD_MAX_DIGITS : widest supported counter, in decades
// - bcd_digit_t    : one BCD decade
// - int_to_bcd     : integer -> packed BCD, digit 0 in [3:0]
// - bcd_is_legal   : every digit <= 9 and decimal value < modulus
// - pow10          : 10**n, used for the parameter range check
package bcdcnt_pkg;

  localparam int unsigned BCD_W          = 4;
  localparam int unsigned BCD_MAX_DIGITS = 4;
  localparam int unsigned BCD_VEC_W      = BCD_W * BCD_MAX_DIGITS;

  typedef logic [BCD_W-1:0] bcd_digit_t;

  function automatic logic [BCD_VEC_W-1:0] int_to_bcd(input int unsigned val);
    logic [BCD_VEC_W-1:0] res;
    int unsigned          rem;
    res = '0;
    rem = val;
    for (int i = 0; i < int'(BCD_MAX_DIGITS); i++) begin
      res[i*BCD_W +: BCD_W] = bcd_digit_t'(rem % 10);
      rem = rem / 10;
    end
    return res;
  endfunction

  // Callers zero-extend narrower vectors, so unused upper decades read as 0.
  function automatic logic bcd_is_legal(input logic [BCD_VEC_W-1:0] val,
                                        input int unsigned         modulus);
    logic        ok;
    int unsigned dec;
    bcd_digit_t  d;
    ok  = 1'b1;
    dec = 0;
    for (int i = int'(BCD_MAX_DIGITS) - 1; i >= 0; i--) begin
      d = val[i*BCD_W +: BCD_W];
      if (d > 4'd9) ok = 1'b0;
      dec = dec * 10 + 32'(d);
    end
    return ok && (dec < modulus);
  endfunction

  function automatic int unsigned pow10(input int unsigned n);
    int unsigned p;
    p = 1;
    for (int unsigned i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade of the modulo counter.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clr_i         : synchronous clear to 0 (highest priority)
//   set_i         : synchronous set to set_val_i (load / terminal reload)
//   set_val_i     : value written on set_i
//   en_i          : step one position in direction up_i
//   up_i          : 1 = increment, 0 = decrement
//   digit_o       : registered digit value
//   cy_o          : en_i while the digit is about to wrap (9->0 up, 0->9 down);
//                   enables the next decade
module bcd_digit
  import bcdcnt_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clr_i,
  input  logic       set_i,
  input  bcd_digit_t set_val_i,
  input  logic       en_i,
  input  logic       up_i,
  output bcd_digit_t digit_o,
  output logic       cy_o
);

  bcd_digit_t digit_d, digit_q;

  always_comb begin
    digit_d = digit_q;
    if (clr_i) begin
      digit_d = '0;
    end else if (set_i) begin
      digit_d = set_val_i;
    end else if (en_i) begin
      if (up_i) digit_d = (digit_q == 4'd9) ? 4'd0 : digit_q + 4'd1;
      else      digit_d = (digit_q == 4'd0) ? 4'd9 : digit_q - 4'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) digit_q <= '0;
    else         digit_q <= digit_d;
  end

  assign digit_o = digit_q;
  assign cy_o    = en_i & (up_i ? (digit_q == 4'd9) : (digit_q == 4'd0));

endmodule

// File: rtl/bcd_mod_counter.sv
// Multi-digit BCD up/down modulo counter with synchronous clear, parallel load,
// cascadable carry and a sticky load-error flag.
// Parameters: DIGITS (1..4 decades), MODULUS (2..10**DIGITS), counts 0..MODULUS-1.
// Ports:
//   CLK, RESET : rising-edge clock, asynchronous active-low reset
//   ENABLE     : count enable (cascade input)
//   UP         : 1 = increment, 0 = decrement
//   CLR        : synchronous clear (beats LOAD and ENABLE), also clears ERR
//   LOAD       : synchronous load of LOAD_VAL; illegal value loads 0 and sets ERR
//   LOAD_VAL   : BCD load value, digit 0 in [3:0]
//   COUNT      : registered BCD count
//   TC         : terminal state (MODULUS-1 counting up, 0 counting down)
//   CARRY      : ENABLE & TC, feeds the next stage's ENABLE
//   ERR        : sticky load-error flag
// Build option: define BCDCNT_SAT_EN to saturate at the terminal instead of wrapping.
module bcd_mod_counter
  import bcdcnt_pkg::*;
#(
  parameter int unsigned DIGITS  = 2,
  parameter int unsigned MODULUS = 60
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    ENABLE,
  input  logic                    UP,
  input  logic                    CLR,
  input  logic                    LOAD,
  input  logic [BCD_W*DIGITS-1:0] LOAD_VAL,
  output logic [BCD_W*DIGITS-1:0] COUNT,
  output logic                    TC,
  output logic                    CARRY,
  output logic                    ERR
);

  localparam int unsigned CntW = BCD_W * DIGITS;
  localparam logic [CntW-1:0] MaxCount = CntW'(int_to_bcd(MODULUS - 1));

  if (DIGITS == 0 || DIGITS > BCD_MAX_DIGITS || MODULUS < 2 || MODULUS > pow10(DIGITS))
  begin : g_bad_cfg
    $error("bcd_mod_counter: illegal DIGITS/MODULUS combination");
  end

  logic            load_ok;
  logic            step;
  logic            digit_set;
  logic [CntW-1:0] set_val;
  logic [DIGITS-1:0] digit_en;
  logic [DIGITS-1:0] digit_cy;
  logic            err_d, err_q;

  assign TC      = UP ? (COUNT == MaxCount) : (COUNT == '0);
  assign CARRY   = ENABLE & TC;
  assign load_ok = bcd_is_legal(BCD_VEC_W'(LOAD_VAL), MODULUS);

  // CLR is handled inside each digit; here only LOAD, terminal reload and stepping.
  always_comb begin
    digit_set = 1'b0;
    set_val   = '0;
    step      = 1'b0;
    if (!CLR) begin
      if (LOAD) begin
        digit_set = 1'b1;
        set_val   = load_ok ? LOAD_VAL : '0;
      end else if (ENABLE) begin
        if (!TC) begin
          step = 1'b1;
        end else begin
`ifdef BCDCNT_SAT_EN
          // Saturate: terminal value simply holds.
          digit_set = 1'b0;
`else
          digit_set = 1'b1;
          set_val   = UP ? '0 : MaxCount;
`endif
        end
      end
    end
  end

  always_comb begin
    err_d = err_q;
    if (CLR)                 err_d = 1'b0;
    else if (LOAD && !load_ok) err_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign ERR = err_q;

  for (genvar i = 0; i < int'(DIGITS); i++) begin : g_digit
    // Decade i steps only when every lower decade wraps on this edge.
    if (i == 0) begin : g_lsd
      assign digit_en[i] = step;
    end else begin : g_upper
      assign digit_en[i] = digit_cy[i-1];
    end

    bcd_digit u_digit (
      .clk_i     (CLK),
      .rst_ni    (RESET),
      .clr_i     (CLR),
      .set_i     (digit_set),
      .set_val_i (set_val[i*BCD_W +: BCD_W]),
      .en_i      (digit_en[i]),
      .up_i      (UP),
      .digit_o   (COUNT[i*BCD_W +: BCD_W]),
      .cy_o      (digit_cy[i])
    );
  end

  // The top decade's wrap is already covered by the terminal detect.
  logic unused_cy;
  assign unused_cy = digit_cy[DIGITS-1];

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Scoreboard bench: a decimal reference model predicts each edge's result for a
// MODULUS-60 and a MODULUS-24 counter driven with identical inputs, plus a
// two-stage 60x60 cascade.
module tb_bcd_mod_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       en, up, clr, load;
  logic [7:0] ldv;
  logic [7:0] cnt60, cnt24;
  logic       tc60, cy60, err60, tc24, cy24, err24;

  logic       cen;
  logic [7:0] ccnt0, ccnt1;
  logic       ctc0, ccy0, cerr0, ctc1, ccy1, cerr1;

  bcd_mod_counter #(.DIGITS(2), .MODULUS(60)) u_dut60 (
    .CLK(clk), .RESET(rst_n), .ENABLE(en), .UP(up), .CLR(clr), .LOAD(load),
    .LOAD_VAL(ldv), .COUNT(cnt60), .TC(tc60), .CARRY(cy60), .ERR(err60)
  );

  bcd_mod_counter #(.DIGITS(2), .MODULUS(24)) u_dut24 (
    .CLK(clk), .RESET(rst_n), .ENABLE(en), .UP(up), .CLR(clr), .LOAD(load),
    .LOAD_VAL(ldv), .COUNT(cnt24), .TC(tc24), .CARRY(cy24), .ERR(err24)
  );

  bcd_mod_counter #(.DIGITS(2), .MODULUS(60)) u_casc0 (
    .CLK(clk), .RESET(rst_n), .ENABLE(cen), .UP(1'b1), .CLR(1'b0), .LOAD(1'b0),
    .LOAD_VAL(8'h00), .COUNT(ccnt0), .TC(ctc0), .CARRY(ccy0), .ERR(cerr0)
  );

  bcd_mod_counter #(.DIGITS(2), .MODULUS(60)) u_casc1 (
    .CLK(clk), .RESET(rst_n), .ENABLE(ccy0), .UP(1'b1), .CLR(1'b0), .LOAD(1'b0),
    .LOAD_VAL(8'h00), .COUNT(ccnt1), .TC(ctc1), .CARRY(ccy1), .ERR(cerr1)
  );

  typedef struct {
    int unsigned id;
    logic [7:0]  cnt;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   m_cnt[2];
  bit   m_err[2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic int unsigned modulus_of(input int id);
    return (id == 0) ? 60 : 24;
  endfunction

  // Decimal reference model of one clock edge.
  function automatic void model_next(input int unsigned md, input int cur, input bit err,
                                     input logic c, input logic l, input logic [7:0] lv,
                                     input logic e, input logic u,
                                     output int nxt, output bit nerr);
    int dec;
    bit ok;
    bit tc;
    nxt  = cur;
    nerr = err;
    if (c) begin
      nxt  = 0;
      nerr = 1'b0;
    end else if (l) begin
      ok  = (lv[7:4] <= 4'd9) && (lv[3:0] <= 4'd9);
      dec = int'(lv[7:4]) * 10 + int'(lv[3:0]);
      if (ok && dec < int'(md)) nxt = dec;
      else begin
        nxt  = 0;
        nerr = 1'b1;
      end
    end else if (e) begin
      tc = u ? (cur == int'(md) - 1) : (cur == 0);
      if (!tc) nxt = u ? cur + 1 : cur - 1;
      else begin
`ifdef BCDCNT_SAT_EN
        nxt = cur;
`else
        nxt = u ? 0 : int'(md) - 1;
`endif
      end
    end
  endfunction

  // Drive one cycle of inputs at the negedge, predict, compare after the posedge.
  task automatic step(input logic c, input logic l, input logic [7:0] lv,
                      input logic e, input logic u);
    exp_t x;
    int   nxt;
    bit   nerr;
    clr = c; load = l; ldv = lv; en = e; up = u;
    for (int i = 0; i < 2; i++) begin
      model_next(modulus_of(i), m_cnt[i], m_err[i], c, l, lv, e, u, nxt, nerr);
      m_cnt[i] = nxt;
      m_err[i] = nerr;
      x.id  = i;
      x.cnt = to_bcd(nxt);
      x.err = nerr;
      sb_q.push_back(x);
    end
    @(posedge clk);
    #1;
    while (sb_q.size() > 0) begin
      x = sb_q.pop_front();
      if (x.id == 0) begin
        check("count60", 32'(cnt60), 32'(x.cnt));
        check("err60", 32'(err60), 32'(x.err));
      end else begin
        check("count24", 32'(cnt24), 32'(x.cnt));
        check("err24", 32'(err24), 32'(x.err));
      end
    end
    @(negedge clk);
  endtask

  task automatic check_comb();
    bit tce;
    for (int i = 0; i < 2; i++) begin
      tce = up ? (m_cnt[i] == int'(modulus_of(i)) - 1) : (m_cnt[i] == 0);
      if (i == 0) begin
        check("tc60", 32'(tc60), 32'(tce));
        check("carry60", 32'(cy60), 32'(en & tce));
      end else begin
        check("tc24", 32'(tc24), 32'(tce));
        check("carry24", 32'(cy24), 32'(en & tce));
      end
    end
  endtask

  initial begin
    int  c0, c1, n0, n1, adv, madv;
    bit  e0, e1, tc0;
    logic [7:0] prev1;

    rst_n = 1'b0;
    en = 1'b0; up = 1'b1; clr = 1'b0; load = 1'b0; ldv = 8'h00; cen = 1'b0;
    m_cnt = '{0, 0};
    m_err = '{1'b0, 1'b0};

    // Reset state, TC follows UP while in reset.
    #12;
    check("rst_count60", 32'(cnt60), 32'h00);
    check("rst_err60", 32'(err60), 32'h0);
    check_comb();
    up = 1'b0; en = 1'b1;
    #1;
    check_comb();
    en = 1'b0; up = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;

    // Count up to the terminal and wrap.
    repeat (59) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    check("count60_at_59", 32'(cnt60), 32'h59);
    check_comb();
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    check_comb();

    // Down: 00 -> 59, then 10 -> 09 borrow.
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    check_comb();
    step(1'b0, 1'b1, 8'h10, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

    // Load legality and sticky ERR.
    step(1'b0, 1'b1, 8'h23, 1'b0, 1'b1);
    step(1'b0, 1'b1, 8'h24, 1'b0, 1'b1);
    step(1'b0, 1'b1, 8'h1A, 1'b0, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);

    // CLR beats LOAD and ENABLE.
    step(1'b0, 1'b1, 8'h37, 1'b0, 1'b1);
    step(1'b1, 1'b1, 8'h55, 1'b1, 1'b1);

    // Asynchronous reset mid-count.
    step(1'b0, 1'b1, 8'h42, 1'b0, 1'b1);
    check("count60_pre_rst", 32'(cnt60), 32'h42);
    #2;
    rst_n = 1'b0;
    #1;
    check("count60_async_rst", 32'(cnt60), 32'h00);
    check("err24_async_rst", 32'(err24), 32'h0);
    m_cnt = '{0, 0};
    m_err = '{1'b0, 1'b0};
    @(negedge clk);
    rst_n = 1'b1;

    // Terminal behaviour (wrap by default, hold when saturating).
    step(1'b0, 1'b1, 8'h59, 1'b0, 1'b1);
    en = 1'b1;
    #1;
    check_comb();
    repeat (5) begin
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
      check_comb();
    end
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    repeat (3) begin
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      check_comb();
    end

    // Random mix.
    repeat (60) begin
      step(1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 5) == 0),
           {4'($urandom_range(0, 6)), 4'($urandom_range(0, 10))},
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      check_comb();
    end
    en = 1'b0;

    // Cascade 60 x 60 for 3600 edges.
    c0 = 0; c1 = 0; adv = 0; madv = 0;
    cen = 1'b1;
    for (int k = 0; k < 3600; k++) begin
      tc0 = (c0 == 59);
      e0  = 1'b1;
      e1  = e0 & tc0;
      model_next(60, c0, 1'b0, 1'b0, 1'b0, 8'h00, e0, 1'b1, n0, e0);
      model_next(60, c1, 1'b0, 1'b0, 1'b0, 8'h00, e1, 1'b1, n1, e0);
      if (n1 != c1) madv++;
      c0 = n0;
      c1 = n1;
      prev1 = ccnt1;
      @(posedge clk);
      #1;
      if (ccnt1 != prev1) adv++;
      if (k == 59) check("casc1_after_60", 32'(ccnt1), 32'(to_bcd(c1)));
      @(negedge clk);
    end
    cen = 1'b0;
    check("casc0_final", 32'(ccnt0), 32'(to_bcd(c0)));
    check("casc1_final", 32'(ccnt1), 32'(to_bcd(c1)));
    check("casc1_advances", 32'(adv), 32'(madv));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bcd_mod_counter.md
# bcd_mod_counter

Parametrised multi-digit BCD up/down modulo counter with synchronous clear, parallel load, cascadable carry and a sticky load-error flag. It is the general counter primitive for the clock/timer datapaths: seconds/minutes (MODULUS 60), hours (24 or 12) and longer decimal spans. Instances are chained through ENABLE/CARRY.

## Interface
- DIGITS, 2, number of BCD decades (1–4)
- MODULUS, 60, count range 0..MODULUS-1; legal range 2 ≤ MODULUS ≤ 10**DIGITS; other values are an elaboration error
- CLK  in  1  rising-edge clock
- RESET  in  1  asynchronous, active-low reset
- ENABLE  in  1  count enable (cascade input)
- UP  in  1  direction: 1 = increment, 0 = decrement
- CLR  in  1  synchronous clear to 0
- LOAD  in  1  synchronous parallel load
- LOAD_VAL  in  4*DIGITS  BCD value to load, digit 0 in [3:0]
- COUNT  out  4*DIGITS  current BCD value, registered
- TC  out  1  terminal state, combinational: UP=1 → COUNT==MODULUS-1; UP=0 → COUNT==0
- CARRY  out  1  ENABLE & TC, combinational; drives the next stage's ENABLE
- ERR  out  1  sticky load-error flag, registered

## Operation
- Per-edge priority: CLR > LOAD > ENABLE count > hold.
- CLR=1: COUNT←0, ERR←0.
- LOAD=1 (CLR=0): LOAD_VAL is legal if every digit ≤ 9 and its decimal value < MODULUS. Legal → COUNT←LOAD_VAL, ERR unchanged. Illegal → COUNT←0, ERR←1.
- ENABLE=1, UP=1: TC=0 → COUNT+1 in BCD (digit 9 rolls to 0 and increments the next digit); TC=1 → COUNT←0.
- ENABLE=1, UP=0: TC=0 → COUNT−1 in BCD (digit 0 rolls to 9 and borrows from the next digit); TC=1 → COUNT←MODULUS-1 in BCD.
- ENABLE=0: COUNT holds. TC still tracks COUNT and UP. CARRY=0.
- UP may change on any cycle. TC and CARRY re-evaluate combinationally in the same cycle.
- COUNT never leaves the range 0..MODULUS-1 and never holds a non-BCD digit.
- ERR clears only on RESET or CLR.

## Timing
- Reset (RESET=0, asynchronous): COUNT=0, ERR=0. TC=1 if UP=0, otherwise 0. CARRY follows ENABLE & TC.
- Reset release: the first active edge behaves per Operation. No recovery cycles are required.
- Latency: COUNT, ERR update one CLK edge after the sampled inputs. TC and CARRY have zero-cycle latency from COUNT, UP and ENABLE.
- Cascade: a stage whose ENABLE is the previous stage's CARRY advances on the same edge the previous stage wraps.
- A RESET asserted mid-count overrides everything immediately. LOAD and CLR in the same cycle: CLR wins, ERR←0.

## Configuration
- BCDCNT_SAT_EN defined: saturating mode.
  - UP=1 at MODULUS-1 holds MODULUS-1.
  - UP=0 at 0 holds 0.
  - TC and CARRY are unchanged (CARRY asserts every enabled cycle at the terminal).
  - Load and clear are unchanged.
- BCDCNT_SAT_EN undefined: wrap-around behaviour as in Operation (default build).

## Structure
- Package bcdcnt_pkg:
  - constant BCD_W=4
  - BCD digit typedef
  - function converting an integer to a DIGITS-wide BCD vector, used for MODULUS-1 and the legality compare
  - function for the BCD legality check
- Sub-module bcd_digit, instantiated DIGITS times. It is one decade with:
  - inc/dec enable in
  - direction
  - wrap-to-9/wrap-to-0 carry/borrow out
  - synchronous set value for terminal reload
- The top level handles:
  - terminal detect against the package constant
  - load/clear priority
  - ERR register
  - saturation gating

## Test plan
- Reset, then ENABLE=1, UP=1, DIGITS=2, MODULUS=60, 59 edges → COUNT=0x59, TC=1, CARRY=1. Next edge → COUNT=0x00, TC=0.
- UP=0 from COUNT=0x00 → COUNT=0x59 on the next edge; 0x10 → 0x09 (digit borrow).
- MODULUS=24: LOAD_VAL=0x23 → COUNT=0x23, ERR=0. LOAD_VAL=0x24 → COUNT=0x00, ERR=1. LOAD_VAL=0x1A → COUNT=0x00, ERR stays 1. CLR → ERR=0.
- Two cascaded 60-counters (second ENABLE = first CARRY), 3600 enabled edges from 0 → both COUNT=0x00; second stage advanced exactly 60 times.
- CLR, LOAD=1 and ENABLE=1 together with COUNT=0x37 → COUNT=0x00. RESET pulsed low mid-count at 0x42 → COUNT=0x00 immediately, without waiting for CLK.
- BCDCNT_SAT_EN, MODULUS=60: at 0x59 with UP=1 for 5 edges → COUNT stays 0x59, CARRY=1. At 0x00 with UP=0 → stays 0x00.
